// File: rtl/alu181_pkg.sv
// Shared opcode constants and sequencer state encoding for the nibble-serial
// 74181 initiator and its bench.
package alu181_pkg;

    localparam logic [3:0] S_ADD = 4'b1001;
    localparam logic       M_ADD = 1'b0;
    localparam logic [3:0] S_SUB = 4'b0110;
    localparam logic       M_SUB = 1'b0;
    localparam logic [3:0] S_AND = 4'b1011;
    localparam logic       M_AND = 1'b1;
    localparam logic [3:0] S_XOR = 4'b0110;
    localparam logic       M_XOR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu181_slice.sv
// Behavioural 74181 4-bit ALU slice (active-high data, active-low carries),
// used as the external slice hanging off the sequencer.
module alu181_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       cnb,
    output logic [3:0] f,
    output logic       cn4b,
    output logic       aeb
);

    logic [3:0] p_s;
    logic [3:0] g_s;
    logic [4:0] sum_s;

    // Arithmetic is P plus G plus carry; logic mode is the XNOR of the same terms.
    always_comb begin
        p_s   = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
        g_s   = (a & b & {4{s[3]}}) | (a & ~b & {4{s[2]}});
        sum_s = {1'b0, p_s} + {1'b0, g_s} + {4'b0000, ~cnb};
        if (m) begin
            f = ~(p_s ^ g_s);
        end else begin
            f = sum_s[3:0];
        end
        cn4b = ~sum_s[4];
        aeb  = (f == 4'hF);
    end

endmodule

// File: rtl/alu181_nibble_sequencer.sv
// Drives one 74181 slice nibble by nibble (LSB first), chaining its carry-out
// back to carry-in, and returns the assembled wide result on a handshake.
module alu181_nibble_sequencer
    import alu181_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [3:0]             cmd_s,
    input  logic                   cmd_m,
    input  logic                   cmd_cnb,
    input  logic [4*NIBBLES-1:0]   cmd_a,
    input  logic [4*NIBBLES-1:0]   cmd_b,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [3:0]             alu_s,
    output logic                   alu_m,
    output logic                   alu_cnb,
    input  logic [3:0]             alu_f,
    input  logic                   alu_cn4b,
    input  logic                   alu_aeb,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [4*NIBBLES-1:0]   rsp_f,
    output logic                   rsp_cn4b,
    output logic                   rsp_aeb,
    output logic                   busy
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [IDX_W-1:0]   idx_r;
    logic [IDX_W-1:0]   idx_nxt_s;
    logic               last_s;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic [W-1:0]       result_r;
    logic [W-1:0]       result_nxt_s;
    logic               aeb_acc_r;
    logic               aeb_nxt_s;

    logic               cmd_ready_r;
    logic               busy_r;
    logic               rsp_valid_r;
    logic [W-1:0]       rsp_f_r;
    logic               rsp_cn4b_r;
    logic               rsp_aeb_r;
    logic [3:0]         alu_a_r;
    logic [3:0]         alu_b_r;
    logic [3:0]         alu_s_r;
    logic               alu_m_r;
    logic               alu_cnb_r;

    assign cmd_ready = cmd_ready_r;
    assign busy      = busy_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_f     = rsp_f_r;
    assign rsp_cn4b  = rsp_cn4b_r;
    assign rsp_aeb   = rsp_aeb_r;
    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign alu_s     = alu_s_r;
    assign alu_m     = alu_m_r;
    assign alu_cnb   = alu_cnb_r;

    // Next-state and per-nibble merge of the slice result.
    always_comb begin
        state_nxt_s  = state_r;
        idx_nxt_s    = idx_r + IDX_ONE;
        last_s       = (idx_r == LAST_IDX);
        result_nxt_s = result_r;
        result_nxt_s[{idx_r, 2'b00} +: 4] = alu_f;
        aeb_nxt_s    = aeb_acc_r & alu_aeb;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, datapath and registered outputs; slice drives are preloaded one
    // edge ahead so alu_* always present the nibble currently being processed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            idx_r       <= '0;
            a_r         <= '0;
            b_r         <= '0;
            result_r    <= '0;
            aeb_acc_r   <= 1'b1;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_f_r     <= '0;
            rsp_cn4b_r  <= 1'b1;
            rsp_aeb_r   <= 1'b0;
            alu_a_r     <= 4'h0;
            alu_b_r     <= 4'h0;
            alu_s_r     <= 4'h0;
            alu_m_r     <= 1'b0;
            alu_cnb_r   <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            cmd_ready_r <= (state_nxt_s == ST_IDLE);
            busy_r      <= (state_nxt_s != ST_IDLE);
            rsp_valid_r <= (state_nxt_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        a_r       <= cmd_a;
                        b_r       <= cmd_b;
                        idx_r     <= '0;
                        aeb_acc_r <= 1'b1;
                        alu_a_r   <= cmd_a[3:0];
                        alu_b_r   <= cmd_b[3:0];
                        alu_s_r   <= cmd_s;
                        alu_m_r   <= cmd_m;
                        alu_cnb_r <= cmd_cnb;
                    end
                end
                ST_RUN: begin
                    result_r  <= result_nxt_s;
                    aeb_acc_r <= aeb_nxt_s;
                    if (last_s) begin
                        rsp_f_r    <= result_nxt_s;
                        rsp_cn4b_r <= alu_cn4b;
                        rsp_aeb_r  <= aeb_nxt_s;
                        alu_a_r    <= 4'h0;
                        alu_b_r    <= 4'h0;
                        alu_s_r    <= 4'h0;
                        alu_m_r    <= 1'b0;
                        alu_cnb_r  <= 1'b1;
                    end else begin
                        idx_r     <= idx_nxt_s;
                        alu_a_r   <= a_r[{idx_nxt_s, 2'b00} +: 4];
                        alu_b_r   <= b_r[{idx_nxt_s, 2'b00} +: 4];
                        alu_cnb_r <= alu_cn4b;
                    end
                end
                ST_DONE: begin
                    idx_r <= idx_r;
                end
                default: begin
                    idx_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu181_nibble_sequencer.sv
// Table-driven, scoreboarded bench for the nibble sequencer with a behavioural
// 74181 slice closing the loop.
module tb_alu181_nibble_sequencer;
    import alu181_pkg::*;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_s = 4'h0;
    logic        cmd_m = 1'b0;
    logic        cmd_cnb = 1'b1;
    logic [15:0] cmd_a = 16'h0;
    logic [15:0] cmd_b = 16'h0;
    logic [3:0]  alu_a, alu_b, alu_s, alu_f;
    logic        alu_m, alu_cnb, alu_cn4b, alu_aeb;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_f;
    logic        rsp_cn4b, rsp_aeb, busy;

    always #5 clk = ~clk;

    alu181_nibble_sequencer #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_s(cmd_s), .cmd_m(cmd_m), .cmd_cnb(cmd_cnb),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m),
        .alu_cnb(alu_cnb), .alu_f(alu_f), .alu_cn4b(alu_cn4b), .alu_aeb(alu_aeb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_f(rsp_f), .rsp_cn4b(rsp_cn4b), .rsp_aeb(rsp_aeb), .busy(busy)
    );

    alu181_slice slice (
        .a(alu_a), .b(alu_b), .s(alu_s), .m(alu_m), .cnb(alu_cnb),
        .f(alu_f), .cn4b(alu_cn4b), .aeb(alu_aeb)
    );

    typedef struct {
        logic [3:0]  s;
        logic        m;
        logic        cnb;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] f;
        logic        cn4b;
        logic        aeb;
        logic        chk_c;
    } vec_t;

    typedef struct {
        logic [15:0] f;
        logic        cn4b;
        logic        aeb;
        logic        chk_c;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[10];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.f = v.f; e.cn4b = v.cn4b; e.aeb = v.aeb; e.chk_c = v.chk_c;
        sb_q.push_back(e);
    endtask

    task automatic drive_cmd(input vec_t v);
        cmd_s = v.s; cmd_m = v.m; cmd_cnb = v.cnb; cmd_a = v.a; cmd_b = v.b;
        cmd_valid = 1'b1;
    endtask

    // Offer a command until accepted (bounded); returns just after the accept edge.
    task automatic issue(input string name, input vec_t v);
        logic acc;
        bit   ok;
        ok = 1'b0;
        drive_cmd(v);
        for (int i = 0; i < 30; i++) begin
            acc = cmd_ready;
            tick();
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        cmd_valid = 1'b0;
        if (ok) push_exp(v);
        else chk({name, "_accept"}, 32'd0, 32'd1);
    endtask

    // Wait for a response (bounded), compare against the scoreboard, then consume it.
    task automatic await_rsp(input string name, input int exp_lat);
        int   lat;
        exp_t e;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (exp_lat >= 0) chk({name, "_latency"}, lat, exp_lat);
        if (!rsp_valid) begin
            chk({name, "_rsp_timeout"}, 32'd0, 32'd1);
        end else if (sb_q.size() == 0) begin
            chk({name, "_unexpected_rsp"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_f"}, rsp_f, e.f);
            chk({name, "_aeb"}, rsp_aeb, e.aeb);
            if (e.chk_c) chk({name, "_cn4b"}, rsp_cn4b, e.cn4b);
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            chk({name, "_valid_drop"}, rsp_valid, 1'b0);
        end
    endtask

    initial begin
        vec_t v, v2;
        logic prev_c;
        int   seen;

        vecs[0] = '{S_ADD, M_ADD, 1'b1, 16'h00FF, 16'h0001, 16'h0100, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{S_ADD, M_ADD, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{S_SUB, M_SUB, 1'b0, 16'h1234, 16'h0034, 16'h1200, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{S_SUB, M_SUB, 1'b1, 16'hBEEF, 16'hBEEF, 16'hFFFF, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{S_SUB, M_SUB, 1'b1, 16'hBEEF, 16'hBEEE, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{S_AND, M_AND, 1'b1, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{S_AND, M_AND, 1'b0, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{S_XOR, M_XOR, 1'b1, 16'hA5A5, 16'h0FF0, 16'hAA55, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{S_ADD, M_ADD, 1'b0, 16'h1234, 16'h4321, 16'h5556, 1'b1, 1'b0, 1'b1};
        vecs[9] = '{S_ADD, M_ADD, 1'b1, 16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b1};

        tick();
        tick();
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_f", rsp_f, 16'h0000);
        chk("rst_rsp_cn4b", rsp_cn4b, 1'b1);
        chk("rst_rsp_aeb", rsp_aeb, 1'b0);
        chk("rst_alu_a", {alu_a, alu_b, alu_s}, 12'h000);
        chk("rst_alu_m", alu_m, 1'b0);
        chk("rst_alu_cnb", alu_cnb, 1'b1);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            issue($sformatf("vec%0d", i), vecs[i]);
            await_rsp($sformatf("vec%0d", i), N);
        end

        // Carry chaining in logic mode: alu_cnb starts at cmd_cnb, then follows the slice.
        v = vecs[5];
        drive_cmd(v);
        tick();
        cmd_valid = 1'b0;
        push_exp(v);
        chk("and_cnb0", alu_cnb, 1'b1);
        chk("and_busy", busy, 1'b1);
        chk("and_cmd_ready", cmd_ready, 1'b0);
        chk("and_sm", {alu_s, alu_m}, {S_AND, M_AND});
        chk("and_a0", alu_a, v.a[3:0]);
        prev_c = alu_cn4b;
        for (int i = 1; i < N; i++) begin
            tick();
            chk($sformatf("and_cnb%0d", i), alu_cnb, prev_c);
            chk($sformatf("and_a%0d", i), alu_a, 4'((v.a >> (4 * i)) & 16'h000F));
            prev_c = alu_cn4b;
        end
        await_rsp("and_seq", 1);
        chk("idle_alu_cnb", alu_cnb, 1'b1);

        // Backpressure with a second command waiting behind the response.
        v  = '{S_ADD, M_ADD, 1'b1, 16'h1111, 16'h2222, 16'h3333, 1'b1, 1'b0, 1'b1};
        v2 = '{S_ADD, M_ADD, 1'b1, 16'h0FFF, 16'h0001, 16'h1000, 1'b1, 1'b0, 1'b1};
        issue("bp1", v);
        seen = 0;
        while (!rsp_valid && seen < 40) begin
            tick();
            seen++;
        end
        drive_cmd(v2);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold_valid%0d", i), rsp_valid, 1'b1);
            chk($sformatf("bp_hold_f%0d", i), rsp_f, 16'h3333);
            chk($sformatf("bp_hold_ready%0d", i), cmd_ready, 1'b0);
            tick();
        end
        await_rsp("bp1", 0);
        chk("bp_no_same_cycle", busy, 1'b0);
        chk("bp_ready_idle", cmd_ready, 1'b1);
        tick();
        chk("bp_accept_next", busy, 1'b1);
        cmd_valid = 1'b0;
        push_exp(v2);
        await_rsp("bp2", N);

        // Reset while RUN is at idx 2: the operation is dropped without a response.
        v = '{S_ADD, M_ADD, 1'b1, 16'h5678, 16'h1111, 16'h6789, 1'b1, 1'b0, 1'b1};
        issue("mid_rst", v);
        tick();
        tick();
        chk("mid_rst_idx2", alu_a, 4'h6);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb_q.delete();
        chk("mid_rst_valid", rsp_valid, 1'b0);
        chk("mid_rst_cnb", alu_cnb, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ready", cmd_ready, 1'b1);
        chk("mid_rst_f", rsp_f, 16'h0000);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rsp_valid) seen++;
        end
        chk("no_stale_rsp", seen, 0);
        v = '{S_ADD, M_ADD, 1'b1, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b1};
        issue("fresh", v);
        await_rsp("fresh", N);

        chk("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
